// File: rtl/video_pkg.sv
// Shared definitions for the character fetch / pixel shifter path:
// fetch FSM states, glyph geometry and character ROM address field layout.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        VRAM_REQ,
        ROM_REQ,
        DONE
    } fetch_state_t;

    localparam int         PIXELS_PER_CHAR = 8;
    localparam int         GFX_BIT         = 10;
    localparam int         CODE_LSB        = 3;
    localparam logic [7:0] BLANK_ROW       = 8'h00;

endpackage

// File: rtl/video_fetch.sv
// Per-cell fetch engine: screen code from video RAM, then glyph row from character ROM,
// into a one-entry pending buffer. VIDEO_SHIFTER_REVERSE_EN enables code-bit7 inverse video.
module video_fetch
    import video_pkg::*;
#(
    parameter int MA_WIDTH = 10,
    parameter int RA_WIDTH = 3,
    parameter int ROM_AW   = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                char_stb,
    input  logic                de,
    input  logic [MA_WIDTH-1:0] ma,
    input  logic [RA_WIDTH-1:0] ra,
    input  logic                gfx,
    output logic                vram_req,
    output logic [MA_WIDTH-1:0] vram_addr,
    input  logic                vram_ack,
    input  logic [7:0]          vram_data,
    output logic                rom_req,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic                rom_ack,
    input  logic [7:0]          rom_data,
    output logic                miss,
    output logic [7:0]          pend_data,
    output logic                pend_valid
);

`ifdef VIDEO_SHIFTER_REVERSE_EN
    localparam bit REVERSE_EN = 1'b1;
`else
    localparam bit REVERSE_EN = 1'b0;
`endif

    fetch_state_t        state_q, state_d;
    logic [RA_WIDTH-1:0] ra_q;
    logic                inv_q;
    logic [ROM_AW-1:0]   rom_addr_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A strobe always restarts the engine, abandoning any fetch still in flight.
    always_comb begin
        state_d = state_q;
        if (char_stb) begin
            state_d = de ? VRAM_REQ : IDLE;
        end else begin
            case (state_q)
                VRAM_REQ: if (vram_ack) state_d = ROM_REQ;
                ROM_REQ:  if (rom_ack)  state_d = DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        rom_addr_d                    = '0;
        rom_addr_d[GFX_BIT]           = gfx;
        rom_addr_d[CODE_LSB +: 7]     = vram_data[6:0];
        rom_addr_d[RA_WIDTH-1:0]      = ra_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vram_addr  <= '0;
            rom_addr   <= '0;
            ra_q       <= '0;
            inv_q      <= 1'b0;
            pend_data  <= BLANK_ROW;
            pend_valid <= 1'b0;
        end else if (char_stb) begin
            pend_valid <= 1'b0;
            if (de) begin
                vram_addr <= ma;
                ra_q      <= ra;
            end
        end else if (state_q == VRAM_REQ && vram_ack) begin
            rom_addr <= rom_addr_d;
            inv_q    <= REVERSE_EN & vram_data[7];
        end else if (state_q == ROM_REQ && rom_ack) begin
            pend_data  <= inv_q ? ~rom_data : rom_data;
            pend_valid <= 1'b1;
        end
    end

    assign vram_req = (state_q == VRAM_REQ);
    assign rom_req  = (state_q == ROM_REQ);
    assign miss     = char_stb && (state_q == VRAM_REQ || state_q == ROM_REQ);

endmodule

// File: rtl/video_shifter.sv
// Character-cell pixel serialiser: fetch engine, 8-bit MSB-first shift register,
// one-slot sync delay and sticky underrun flag. Optional macro: VIDEO_SHIFTER_REVERSE_EN.
module video_shifter
    import video_pkg::*;
#(
    parameter int MA_WIDTH = 10,
    parameter int RA_WIDTH = 3,
    parameter int ROM_AW   = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                char_stb,
    input  logic                de,
    input  logic [MA_WIDTH-1:0] ma,
    input  logic [RA_WIDTH-1:0] ra,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                gfx,
    output logic                vram_req,
    output logic [MA_WIDTH-1:0] vram_addr,
    input  logic                vram_ack,
    input  logic [7:0]          vram_data,
    output logic                rom_req,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic                rom_ack,
    input  logic [7:0]          rom_data,
    output logic                video,
    output logic                hsync,
    output logic                vsync,
    output logic                underrun,
    input  logic                underrun_clr
);

    logic                       miss;
    logic [7:0]                 pend_data;
    logic                       pend_valid;
    logic [PIXELS_PER_CHAR-1:0] shift_q;
    logic                       hs_cap, vs_cap;

    video_fetch #(
        .MA_WIDTH (MA_WIDTH),
        .RA_WIDTH (RA_WIDTH),
        .ROM_AW   (ROM_AW)
    ) u_fetch (
        .clk        (clk),
        .reset      (reset),
        .char_stb   (char_stb),
        .de         (de),
        .ma         (ma),
        .ra         (ra),
        .gfx        (gfx),
        .vram_req   (vram_req),
        .vram_addr  (vram_addr),
        .vram_ack   (vram_ack),
        .vram_data  (vram_data),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .miss       (miss),
        .pend_data  (pend_data),
        .pend_valid (pend_valid)
    );

    // Shifting in zeros means a stretched slot shows blank pixels rather than repeats.
    always_ff @(posedge clk) begin
        if (reset)         shift_q <= '0;
        else if (char_stb) shift_q <= pend_valid ? pend_data : BLANK_ROW;
        else               shift_q <= {shift_q[PIXELS_PER_CHAR-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_cap <= 1'b0;
            vs_cap <= 1'b0;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
        end else if (char_stb) begin
            hs_cap <= hsync_in;
            vs_cap <= vsync_in;
            hsync  <= hs_cap;
            vsync  <= vs_cap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)             underrun <= 1'b0;
        else if (miss)         underrun <= 1'b1;
        else if (underrun_clr) underrun <= 1'b0;
    end

    assign video = shift_q[PIXELS_PER_CHAR-1];

endmodule

// File: tb/tb_video_shifter.sv
// Self-checking bench for video_shifter: a memory responder with per-cell ack delays and
// a cell-level model of what each display slot must show.
module tb_video_shifter;

    typedef struct {
        logic       de;
        logic [9:0] ma;
        logic [2:0] ra;
        logic       hs;
        logic       vs;
        logic       gfx;
        int         vd;
        int         rd;
    } cell_t;

    logic        clk = 1'b0;
    logic        reset, char_stb, de, hsync_in, vsync_in, gfx;
    logic [9:0]  ma;
    logic [2:0]  ra;
    logic        vram_req, rom_req, vram_ack, rom_ack;
    logic [9:0]  vram_addr;
    logic [10:0] rom_addr;
    logic [7:0]  vram_data, rom_data;
    logic        video, hsync, vsync, underrun, underrun_clr;

    logic [7:0]  vram_mem [1024];
    logic [7:0]  rom_mem  [2048];
    cell_t       cells [$];
    cell_t       prev_cell;
    logic        exp_ur;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          vram_delay = 0, rom_delay = 0, vcnt = 0, rcnt = 0;
    bit          resp_en  = 1'b1;
    bit          stb_prev = 1'b0;

    video_shifter dut (
        .clk          (clk),
        .reset        (reset),
        .char_stb     (char_stb),
        .de           (de),
        .ma           (ma),
        .ra           (ra),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .gfx          (gfx),
        .vram_req     (vram_req),
        .vram_addr    (vram_addr),
        .vram_ack     (vram_ack),
        .vram_data    (vram_data),
        .rom_req      (rom_req),
        .rom_addr     (rom_addr),
        .rom_ack      (rom_ack),
        .rom_data     (rom_data),
        .video        (video),
        .hsync        (hsync),
        .vsync        (vsync),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        stb_prev = char_stb;
    end

    // Memory responder: each request is acked after its cell's programmed number of wait cycles.
    initial begin
        vram_ack = 1'b0; rom_ack = 1'b0; vram_data = 8'h00; rom_data = 8'h00;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                vram_ack = 1'b0;
                rom_ack  = 1'b0;
                if (stb_prev) begin vcnt = 0; rcnt = 0; end
                if (vram_req) begin
                    if (vcnt == vram_delay) begin vram_ack = 1'b1; vram_data = vram_mem[vram_addr]; end
                    vcnt++;
                end else vcnt = 0;
                if (rom_req) begin
                    if (rcnt == rom_delay) begin rom_ack = 1'b1; rom_data = rom_mem[rom_addr]; end
                    rcnt++;
                end else rcnt = 0;
            end
        end
    end

    function automatic cell_t mk(logic de_v, logic [9:0] ma_v, logic [2:0] ra_v, logic hs_v,
                                 logic vs_v, logic gfx_v, int vd_v, int rd_v);
        cell_t c;
        c.de = de_v; c.ma = ma_v; c.ra = ra_v; c.hs = hs_v; c.vs = vs_v; c.gfx = gfx_v;
        c.vd = vd_v; c.rd = rd_v;
        return c;
    endfunction

    // The VRAM read takes vd+1 clk and the ROM read rd+1 clk; both must finish before the
    // next strobe, 8 clk after this one.
    function automatic logic cell_misses(cell_t p);
        return p.de && (p.vd + p.rd + 2 >= 8);
    endfunction

    function automatic logic [10:0] glyph_addr(cell_t p);
        logic [7:0] code;
        code = vram_mem[p.ma];
        return {p.gfx, code[6:0], p.ra};
    endfunction

    function automatic logic [7:0] expected_row(cell_t p);
        logic [7:0] code, row;
        if (!p.de || cell_misses(p)) return 8'h00;
        code = vram_mem[p.ma];
        row  = rom_mem[glyph_addr(p)];
`ifdef VIDEO_SHIFTER_REVERSE_EN
        if (code[7]) row = ~row;
`endif
        return row;
    endfunction

    // Plays the queued cells at nominal 8-clk strobe spacing (plus one trailing blank cell) and
    // checks that each slot shows the previous cell's pixels and syncs.
    task automatic run_cells();
        cell_t      c, p;
        logic [7:0] row;
        cells.push_back(mk(1'b0, 10'h000, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0));
        @(negedge clk);
        for (int i = 0; i < cells.size(); i++) begin
            c = cells[i];
            p = prev_cell;
            row = expected_row(p);
            if (cell_misses(p)) exp_ur = 1'b1;
            de = c.de; ma = c.ma; ra = c.ra; hsync_in = c.hs; vsync_in = c.vs; gfx = c.gfx;
            vram_delay = c.vd; rom_delay = c.rd;
            char_stb = 1'b1;
            for (int cyc = 0; cyc < 8; cyc++) begin
                @(negedge clk);
                if (cyc == 0) begin
                    char_stb = 1'b0;
                    n_checks++;
                    if (underrun !== exp_ur) begin
                        n_fail++;
                        $display("[TB] FAIL underrun slot %0d: got %b want %b", i, underrun, exp_ur);
                    end
                    if (c.de) begin
                        n_checks++;
                        if (vram_req !== 1'b1 || vram_addr !== c.ma) begin
                            n_fail++;
                            $display("[TB] FAIL vram_req slot %0d: got req %b addr %h want 1 %h",
                                     i, vram_req, vram_addr, c.ma);
                        end
                    end
                end
                n_checks++;
                if (video !== row[7-cyc]) begin
                    n_fail++;
                    $display("[TB] FAIL pixel slot %0d cyc %0d: got %b want %b", i, cyc, video, row[7-cyc]);
                end
                n_checks++;
                if (hsync !== p.hs || vsync !== p.vs) begin
                    n_fail++;
                    $display("[TB] FAIL sync slot %0d cyc %0d: got %b%b want %b%b",
                             i, cyc, hsync, vsync, p.hs, p.vs);
                end
                if (!c.de) begin
                    n_checks++;
                    if (vram_req !== 1'b0 || rom_req !== 1'b0) begin
                        n_fail++;
                        $display("[TB] FAIL idle_req slot %0d cyc %0d: got %b%b want 00",
                                 i, cyc, vram_req, rom_req);
                    end
                end else if (cyc == c.vd + 1) begin
                    n_checks++;
                    if (rom_req !== 1'b1 || rom_addr !== glyph_addr(c)) begin
                        n_fail++;
                        $display("[TB] FAIL rom_req slot %0d: got req %b addr %h want 1 %h",
                                 i, rom_req, rom_addr, glyph_addr(c));
                    end
                end
            end
            prev_cell = c;
        end
        cells.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; char_stb = 1'b0; de = 1'b0; ma = '0; ra = '0; hsync_in = 1'b0;
        vsync_in = 1'b0; gfx = 1'b0; underrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({video, hsync, vsync, underrun, vram_req, rom_req} !== 6'b0 ||
            vram_addr !== 10'h0 || rom_addr !== 11'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b%b%b%b%b%b %h %h want all zero",
                     video, hsync, vsync, underrun, vram_req, rom_req, vram_addr, rom_addr);
        end
        reset = 1'b0;
        prev_cell = mk(1'b0, 10'h000, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        exp_ur = 1'b0;
    endtask

    task automatic test_basic_fetch();
        vram_mem[10'h123] = 8'h41;
        rom_mem[11'h20D]  = 8'hA5;
        cells.push_back(mk(1'b1, 10'h123, 3'd5, 1'b0, 1'b0, 1'b0, 0, 0));
        run_cells();
    endtask

    task automatic test_blank_cells();
        for (int k = 0; k < 3; k++)
            cells.push_back(mk(1'b0, 10'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b0, 0, 0));
        run_cells();
    endtask

    task automatic test_sync_delay();
        for (int k = 0; k < 4; k++)
            cells.push_back(mk(1'b0, 10'h000, 3'd0, 1'b1, (k == 1), 1'b0, 0, 0));
        run_cells();
    endtask

    task automatic test_reverse();
        vram_mem[10'h055] = 8'h81;
        rom_mem[11'h40A]  = 8'hF0;
        cells.push_back(mk(1'b1, 10'h055, 3'd2, 1'b0, 1'b0, 1'b1, 1, 2));
        run_cells();
    endtask

    task automatic test_underrun();
        cells.push_back(mk(1'b1, 10'h0AA, 3'd1, 1'b0, 1'b0, 1'b0, 5, 5));
        run_cells();
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        exp_ur = 1'b0;
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL underrun_clr: got %b want 0", underrun);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            cells.push_back(mk(($urandom_range(0, 3) != 0), 10'($urandom), 3'($urandom),
                               1'($urandom), 1'($urandom), 1'($urandom),
                               int'($urandom_range(0, 5)), int'($urandom_range(0, 5))));
        run_cells();
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        exp_ur = 1'b0;
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL random_clr: got %b want 0", underrun);
        end
    endtask

    task automatic test_reset_mid_fetch();
        resp_en = 1'b0;
        vram_ack = 1'b0; rom_ack = 1'b0;
        de = 1'b1; ma = 10'h200; ra = 3'd3; char_stb = 1'b1;
        @(negedge clk);
        char_stb = 1'b0;
        n_checks++;
        if (vram_req !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midfetch_req: got %b want 1", vram_req);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vram_ack = 1'b1; vram_data = 8'h41;
        @(negedge clk);
        vram_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({video, hsync, vsync, underrun, vram_req, rom_req} !== 6'b0 ||
                vram_addr !== 10'h0 || rom_addr !== 11'h0) begin
                n_fail++;
                $display("[TB] FAIL midfetch_reset cyc %0d: got %b%b%b%b%b%b %h %h want all zero",
                         k, video, hsync, vsync, underrun, vram_req, rom_req, vram_addr, rom_addr);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) vram_mem[k] = 8'($urandom);
        for (int k = 0; k < 2048; k++) rom_mem[k]  = 8'($urandom);
        test_reset();
        test_basic_fetch();
        test_blank_cells();
        test_sync_delay();
        test_reverse();
        test_underrun();
        test_random();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
